// File: rtl/bcd_counter_n.sv
// rtl/bcd_counter_n.sv - parametrised multi-digit BCD up/down counter with wrap/saturate
module bcd_counter_n #(
    parameter int NDIG     = 2,
    parameter bit SATURATE = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_inc,
    input  logic              d_dec,
    input  logic              d_clr,
    input  logic              d_load,
    input  logic [4*NDIG-1:0] load_val,
    output logic [4*NDIG-1:0] dig,
    output logic              at_zero,
    output logic              at_max,
    output logic              wrap
);

    logic [4*NDIG-1:0] dig_reg;
    logic [4*NDIG-1:0] dig_next;
    logic              wrap_reg;
    logic              wrap_next;

    logic [4*NDIG-1:0] inc_val;
    logic [4*NDIG-1:0] dec_val;
    logic [4*NDIG-1:0] clamp_val;
    logic              inc_carry;
    logic              dec_borrow;
    logic [3:0]        nib;
    logic [3:0]        lnib;

    always_comb begin
        at_zero = 1'b1;
        at_max  = 1'b1;
        for (int k = 0; k < NDIG; k++) begin
            if (dig_reg[4*k +: 4] != 4'd0) at_zero = 1'b0;
            if (dig_reg[4*k +: 4] != 4'd9) at_max  = 1'b0;
        end
    end

    // Ripple carry/borrow across digits; a digit only moves when all lower digits rolled over.
    always_comb begin
        inc_val    = '0;
        dec_val    = '0;
        clamp_val  = '0;
        inc_carry  = 1'b1;
        dec_borrow = 1'b1;
        nib        = 4'd0;
        lnib       = 4'd0;
        for (int k = 0; k < NDIG; k++) begin
            nib = dig_reg[4*k +: 4];
            if (inc_carry)
                inc_val[4*k +: 4] = (nib == 4'd9) ? 4'd0 : nib + 4'd1;
            else
                inc_val[4*k +: 4] = nib;
            inc_carry = inc_carry && (nib == 4'd9);

            if (dec_borrow)
                dec_val[4*k +: 4] = (nib == 4'd0) ? 4'd9 : nib - 4'd1;
            else
                dec_val[4*k +: 4] = nib;
            dec_borrow = dec_borrow && (nib == 4'd0);

            lnib = load_val[4*k +: 4];
            clamp_val[4*k +: 4] = (lnib > 4'd9) ? 4'd9 : lnib;
        end
    end

    always_comb begin
        dig_next  = dig_reg;
        wrap_next = 1'b0;
        if (d_clr) begin
            dig_next = '0;
        end else if (d_load) begin
            dig_next = clamp_val;
        end else if (d_inc && !d_dec) begin
            if (at_max) begin
                if (!SATURATE) begin
                    dig_next  = inc_val;
                    wrap_next = 1'b1;
                end
            end else begin
                dig_next = inc_val;
            end
        end else if (d_dec && !d_inc) begin
            if (at_zero) begin
                if (!SATURATE) begin
                    dig_next  = dec_val;
                    wrap_next = 1'b1;
                end
            end else begin
                dig_next = dec_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dig_reg  <= '0;
            wrap_reg <= 1'b0;
        end else begin
            dig_reg  <= dig_next;
            wrap_reg <= wrap_next;
        end
    end

    assign dig  = dig_reg;
    assign wrap = wrap_reg;

endmodule
